// File: rtl/fsm_responder_if.sv
// Handshake bundle between a four-phase initiator and fsm_responder.
// The master side drives the request and downstream ready; the slave side is the responder.
interface fsm_responder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req;
  logic [WIDTH-1:0] len;
  logic             abort;
  logic             ready;
  logic             ack;
  logic             valid;
  logic [WIDTH-1:0] beat;
  logic             done;
  logic             aborted;
  logic [1:0]       state;

  modport master (
    output req, len, abort, ready,
    input  ack, valid, beat, done, aborted, state
  );

  modport slave (
    input  req, len, abort, ready,
    output ack, valid, beat, done, aborted, state
  );
endinterface

// File: rtl/fsm_responder.sv
// Four-phase request responder that streams len indexed beats under ready backpressure.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module fsm_responder #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clock,
  input logic            resetN,
  fsm_responder_if.slave bus
);

  typedef enum logic [1:0] {
    StWaite = 2'd0,
    StGo    = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] beat_q, beat_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             aborted_q, aborted_d;
  logic             last_beat;

  // len_q is never zero in StGo, so len_q - 1 cannot underflow there.
  assign last_beat = (beat_q == (len_q - One));

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q   <= StWaite;
      beat_q    <= '0;
      len_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    aborted_d = aborted_q;

    case (state_q)
      StWaite: begin
        if (bus.req) begin
          len_d     = bus.len;
          beat_d    = '0;
          aborted_d = 1'b0;
          state_d   = (bus.len == '0) ? StDone : StGo;
        end
      end

      StGo: begin
        // A final handshake wins over a simultaneous abort.
        if (bus.ready && last_beat) begin
          state_d   = StDone;
          aborted_d = 1'b0;
        end else if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (bus.ready) begin
          beat_d = beat_q + One;
        end
      end

      StDone: begin
        if (!bus.req) begin
          state_d   = StWaite;
          beat_d    = '0;
          aborted_d = 1'b0;
        end
      end

      default: begin
        state_d   = StWaite;
        beat_d    = '0;
        len_d     = '0;
        aborted_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.ack     = 1'b0;
    bus.valid   = 1'b0;
    bus.done    = 1'b0;
    bus.aborted = 1'b0;
    bus.beat    = '0;
    bus.state   = state_q;

    case (state_q)
      StGo: begin
        bus.ack   = 1'b1;
        bus.valid = 1'b1;
        bus.beat  = beat_q;
      end
      StDone: begin
        bus.ack     = 1'b1;
        bus.done    = 1'b1;
        bus.aborted = aborted_q;
        bus.beat    = beat_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fsm_responder.md
FSM_RESPONDER -- requirements
Module: fsm_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the beat-count and beat-data width in bits (legal range 2..16).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 1 bit: initiator request, four-phase, level-held until done is observed.
REQ-005 SHALL have port len, input, WIDTH bits: number of beats requested, sampled only when a request is accepted.
REQ-006 SHALL have port abort, input, 1 bit: terminates an active transfer.
REQ-007 SHALL have port ready, input, 1 bit: downstream accepts the current beat.
REQ-008 SHALL have port ack, output, 1 bit: request accepted; high in GO and DONE.
REQ-009 SHALL have port valid, output, 1 bit: beat presented; high only in GO.
REQ-010 SHALL have port beat, output, WIDTH bits: index of the current beat (0..len-1).
REQ-011 SHALL have port done, output, 1 bit: transfer finished; high only in DONE.
REQ-012 SHALL have port aborted, output, 1 bit: the last transfer ended by abort; valid while done=1.
REQ-013 SHALL have port state, output, 2 bits: current state, encoded WAITE=0, GO=1, DONE=2.

Function
REQ-014 SHALL register all outputs; outputs SHALL be decoded from the state and counter registers only, with no combinational path from any input.
REQ-015 In WAITE with req=1 and len!=0, the block SHALL latch len, clear the counter, and enter GO on the next edge.
REQ-016 In WAITE with req=1 and len=0, the block SHALL enter DONE directly with aborted=0 and issue no beats.
REQ-017 In WAITE with req=0, the block SHALL remain in WAITE; abort and ready SHALL be ignored there.
REQ-018 In GO, a beat SHALL transfer on any edge where valid=1 and ready=1; after each transfer beat SHALL increment by 1.
REQ-019 In GO, a transfer with beat = latched len-1 SHALL move the block to DONE on that edge with aborted=0.
REQ-020 In GO with ready=0, beat SHALL hold and valid SHALL stay high; there is no timeout.
REQ-021 In GO, abort=1 without a final transfer SHALL move the block to DONE with aborted=1 on that edge.
REQ-022 Abort on the same edge as the final transfer SHALL count as completion: aborted=0.
REQ-023 In GO, changes on len or req SHALL be ignored; req dropping early SHALL NOT end the transfer.
REQ-024 In DONE, the block SHALL hold done=1 and ack=1 until req=0 is sampled, then enter WAITE on that edge.
REQ-025 In DONE, the aborted flag SHALL hold until the block leaves DONE, and SHALL clear on entry to WAITE.
REQ-026 Latency SHALL be one cycle from req sampled high to ack/valid high; first beat index 0.
REQ-027 A len of 2^WIDTH-1 SHALL produce exactly 2^WIDTH-1 beats; the counter SHALL never wrap within a transfer.
REQ-028 Illegal state encoding 3 SHALL return to WAITE on the next edge with all outputs low.

Reset
REQ-029 When resetN=0 is sampled on a rising clock edge, the block SHALL enter WAITE and clear the counter, latched len, and aborted.
REQ-030 Out of reset, ack, valid, done, and aborted SHALL be 0, beat SHALL be 0, and state SHALL be 0.
REQ-031 Reset asserted mid-transfer (GO or DONE) SHALL take priority over all inputs and abandon the transfer with no done pulse.
REQ-032 The first request SHALL be accepted on the first edge with resetN=1 and req=1.

Verification
REQ-033 Basic transfer: req=1, len=3, ready=1 -> ack and valid rise one cycle later; beats 0,1,2 on consecutive cycles; done=1, aborted=0; req=0 -> WAITE next edge.
REQ-034 Backpressure: len=2, ready toggling 0,1,0,0,1 -> beat 0 held two cycles, beat 1 held three cycles; exactly 2 transfers, then DONE.
REQ-035 Zero length: req=1, len=0 -> state goes 0 to 2 directly; valid never high; done=1 until req=0.
REQ-036 Abort: len=5, abort pulsed at beat 2 with ready=0 -> DONE, aborted=1; abort together with the handshake of beat 4 -> aborted=0.
REQ-037 Reset mid-GO: resetN=0 at beat 1 -> next edge: all outputs 0, state=0; a new req after release starts again at beat 0.
REQ-038 Maximum length: WIDTH=4, len=15, ready=1 -> exactly 15 beats (0..14), no wrap, then done.
